mem_arbiter: RTL and testbench

- Sequences the single shared RAM port between pipeline instruction fetch (I-port) and MEM-stage data access (D-port).
- Sits between fetch/MEM stages and RAM. Its iwait/dwait feed the pipeline stall logic alongside the hazard unit's enables.
- Fixed data priority with an anti-starvation counter for fetch.
- Latched RAM request with a watchdog timeout.

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data RAM arbiter.
// Holds the word type, the arbiter state encoding and the word returned when an access times out.
package mem_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arbstate_t;

  localparam word_t ERR_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Groups the fetch port, the data port and the RAM port that the arbiter sits between.
// The arbiter uses the slave view; the pipeline/RAM environment uses the master view.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  logic  dwait;
  word_t dload;

  logic  ramREN;
  logic  ramWEN;
  word_t ramaddr;
  word_t ramstore;
  word_t ramload;
  logic  ram_ready;

  logic  mem_err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between fetch and data access; data has priority, fetch wins after STARVE_LIMIT losses.
// Latency >= 2 cycles (grant edge + RAM cycle); requesters stall on iwait/dwait until completion or watchdog abort.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255,
  parameter word_t       ERR_WORD     = mem_arbiter_pkg::ERR_WORD
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.slave  bus
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  arbstate_t       state;
  arbstate_t       state_nxt;
  logic [SC_W-1:0] starve_cnt;
  logic [WD_W-1:0] wd_cnt;
  logic            d_req;
  logic            tmo;
  logic            done;
  logic            starved;

  assign d_req   = bus.dREN | bus.dWEN;
  assign starved = (starve_cnt == SC_W'(STARVE_LIMIT));
  // ram_ready takes precedence over the watchdog when both fire together
  assign tmo     = (state != IDLE) && !bus.ram_ready && (wd_cnt == WD_W'(TIMEOUT));
  assign done    = (state != IDLE) && (bus.ram_ready || tmo);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bus.iwait = bus.iREN && !((state == SERVE_I) && done);
    bus.dwait = d_req && !((state == SERVE_D) && done);
    bus.iload = '0;
    bus.dload = '0;

    case (state)
      IDLE: begin
        if (bus.iREN && starved) begin
          state_nxt = SERVE_I;
        end else if (d_req) begin
          state_nxt = SERVE_D;
        end else if (bus.iREN) begin
          state_nxt = SERVE_I;
        end
      end
      SERVE_I: begin
        if (done) begin
          state_nxt = IDLE;
          bus.iload = bus.ram_ready ? bus.ramload : ERR_WORD;
        end
      end
      SERVE_D: begin
        if (done) begin
          state_nxt = IDLE;
          bus.dload = bus.ram_ready ? bus.ramload : ERR_WORD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.ramREN   <= 1'b0;
      bus.ramWEN   <= 1'b0;
      bus.ramaddr  <= '0;
      bus.ramstore <= '0;
      starve_cnt   <= '0;
      wd_cnt       <= '0;
      bus.mem_err  <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (state_nxt == SERVE_I) begin
          bus.ramREN  <= 1'b1;
          bus.ramWEN  <= 1'b0;
          bus.ramaddr <= bus.iaddr;
          starve_cnt  <= '0;
        end else if (state_nxt == SERVE_D) begin
          // a simultaneous read+write request is performed as a write
          bus.ramREN   <= bus.dREN & ~bus.dWEN;
          bus.ramWEN   <= bus.dWEN;
          bus.ramaddr  <= bus.daddr;
          bus.ramstore <= bus.dstore;
          if (bus.iREN && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end
      end else if (done) begin
        bus.ramREN <= 1'b0;
        bus.ramWEN <= 1'b0;
      end

      wd_cnt <= ((state != IDLE) && !done) ? wd_cnt + 1'b1 : '0;

      if (tmo) begin
        bus.mem_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected loads queued at stimulus time, popped when a port completes.
module tb_mem_arbiter;

  logic CLK = 1'b0;
  logic RST;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] iq[$];
  logic [31:0] dq[$];

  mem_arbiter_if bus ();

  mem_arbiter #(
    .STARVE_LIMIT (4),
    .TIMEOUT      (255),
    .ERR_WORD     (32'hBAD1BAD1)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] ram_fn(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C010004;
    return a ^ 32'hA5A50000;
  endfunction

  assign bus.ramload = ram_fn(bus.ramaddr);

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_load(input bit is_d, input logic [31:0] obs);
    logic [31:0] e;
    int          sz;
    sz = is_d ? dq.size() : iq.size();
    if (sz == 0) begin
      n_cmp++;
      assert (sz != 0) else begin
        n_err++;
        $error("FAIL %s_unexpected: observed completion %h expected none", is_d ? "dload" : "iload", obs);
      end
    end else begin
      e = is_d ? dq.pop_front() : iq.pop_front();
      chk(is_d ? "dload" : "iload", obs, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before 100us");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    int d_run;
    int i_grants;

    RST           = 1'b1;
    bus.iREN      = 1'b0;
    bus.iaddr     = '0;
    bus.dREN      = 1'b0;
    bus.dWEN      = 1'b0;
    bus.daddr     = '0;
    bus.dstore    = '0;
    bus.ram_ready = 1'b0;

    // reset state
    cyc(); cyc(); settle();
    chk("rst_ramREN",   bus.ramREN,   1'b0);
    chk("rst_ramWEN",   bus.ramWEN,   1'b0);
    chk("rst_ramaddr",  bus.ramaddr,  32'h0);
    chk("rst_ramstore", bus.ramstore, 32'h0);
    chk("rst_mem_err",  bus.mem_err,  1'b0);
    chk("rst_iwait",    bus.iwait,    1'b0);
    chk("rst_dwait",    bus.dwait,    1'b0);
    RST = 1'b0;
    cyc();

    // fetch only
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h40;
    iq.push_back(32'h8C010004);
    settle();
    chk("f_iwait_req", bus.iwait,  1'b1);
    chk("f_ramREN_0",  bus.ramREN, 1'b0);
    cyc(); settle();
    chk("f_ramREN_1",  bus.ramREN,  1'b1);
    chk("f_ramaddr",   bus.ramaddr, 32'h40);
    bus.ram_ready = 1'b1;
    settle();
    chk("f_iwait_done", bus.iwait, 1'b0);
    chk_load(1'b0, bus.iload);
    cyc();
    bus.iREN      = 1'b0;
    bus.ram_ready = 1'b0;
    settle();
    chk("f_ramREN_clr", bus.ramREN, 1'b0);
    cyc();

    // simultaneous I and D (read+write on D treated as write)
    bus.iREN      = 1'b1;
    bus.iaddr     = 32'h44;
    bus.dREN      = 1'b1;
    bus.dWEN      = 1'b1;
    bus.daddr     = 32'h100;
    bus.dstore    = 32'hDEAD;
    bus.ram_ready = 1'b1;
    iq.push_back(ram_fn(32'h44));
    settle();
    chk("s_iwait_c0", bus.iwait, 1'b1);
    chk("s_dwait_c0", bus.dwait, 1'b1);
    cyc(); settle();
    chk("s_ramWEN",   bus.ramWEN,   1'b1);
    chk("s_ramREN_w", bus.ramREN,   1'b0);
    chk("s_ramaddr_d", bus.ramaddr, 32'h100);
    chk("s_ramstore", bus.ramstore, 32'hDEAD);
    chk("s_dwait_c1", bus.dwait,    1'b0);
    chk("s_iwait_c1", bus.iwait,    1'b1);
    cyc();
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
    settle();
    chk("s_ramWEN_clr", bus.ramWEN, 1'b0);
    chk("s_iwait_c2",   bus.iwait,  1'b1);
    cyc(); settle();
    chk("s_ramREN_i",  bus.ramREN,  1'b1);
    chk("s_ramaddr_i", bus.ramaddr, 32'h44);
    chk("s_iwait_c3",  bus.iwait,   1'b0);
    chk_load(1'b0, bus.iload);
    cyc();
    bus.iREN      = 1'b0;
    bus.ram_ready = 1'b0;
    cyc();

    // starvation: two rounds of 4 D accesses followed by one fetch
    bus.iREN      = 1'b1;
    bus.iaddr     = 32'h80;
    bus.dREN      = 1'b1;
    bus.daddr     = 32'h200;
    bus.ram_ready = 1'b1;
    for (int k = 0; k < 8; k++) dq.push_back(ram_fn(32'h200));
    for (int k = 0; k < 2; k++) iq.push_back(ram_fn(32'h80));
    d_run    = 0;
    i_grants = 0;
    for (int c = 0; c < 40 && i_grants < 2; c++) begin
      cyc(); settle();
      if (bus.ramREN) begin
        if (bus.ramaddr == 32'h200) begin
          d_run++;
        end else if (bus.ramaddr == 32'h80) begin
          chk($sformatf("starve_run%0d", i_grants), d_run, 4);
          d_run = 0;
          i_grants++;
        end
      end
      if (!bus.dwait) chk_load(1'b1, bus.dload);
      if (!bus.iwait) chk_load(1'b0, bus.iload);
    end
    chk("starve_i_grants", i_grants, 2);
    cyc();
    bus.iREN      = 1'b0;
    bus.dREN      = 1'b0;
    bus.ram_ready = 1'b0;
    cyc();

    // watchdog timeout on a data read
    bus.dREN  = 1'b1;
    bus.daddr = 32'h300;
    dq.push_back(32'hBAD1BAD1);
    settle();
    chk("t_dwait_req", bus.dwait, 1'b1);
    n = 0;
    do begin
      cyc(); settle();
      n++;
    end while (bus.dwait && n < 300);
    chk("t_serve_cycle", n, 256);
    chk("t_mem_err_pre", bus.mem_err, 1'b0);
    chk_load(1'b1, bus.dload);
    cyc();
    bus.dREN = 1'b0;
    settle();
    chk("t_mem_err_set", bus.mem_err, 1'b1);

    // mem_err stays set across a normal access
    bus.iREN      = 1'b1;
    bus.iaddr     = 32'h48;
    bus.ram_ready = 1'b1;
    iq.push_back(ram_fn(32'h48));
    cyc(); settle();
    chk("k_iwait", bus.iwait, 1'b0);
    chk_load(1'b0, bus.iload);
    cyc();
    bus.iREN      = 1'b0;
    bus.ram_ready = 1'b0;
    settle();
    chk("k_mem_err_sticky", bus.mem_err, 1'b1);
    cyc();

    // reset in the middle of a data access
    bus.dREN  = 1'b1;
    bus.daddr = 32'h400;
    cyc(); settle();
    chk("r_ramREN_pre",  bus.ramREN,  1'b1);
    chk("r_ramaddr_pre", bus.ramaddr, 32'h400);
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    settle();
    chk("r_ramREN",  bus.ramREN,  1'b0);
    chk("r_ramWEN",  bus.ramWEN,  1'b0);
    chk("r_ramaddr", bus.ramaddr, 32'h0);
    chk("r_mem_err", bus.mem_err, 1'b0);
    chk("r_dwait",   bus.dwait,   1'b1);
    cyc(); settle();
    chk("r_regrant", bus.ramREN, 1'b1);
    bus.ram_ready = 1'b1;
    dq.push_back(ram_fn(32'h400));
    settle();
    chk("r_dwait_done", bus.dwait, 1'b0);
    chk_load(1'b1, bus.dload);
    cyc();
    bus.dREN      = 1'b0;
    bus.ram_ready = 1'b0;
    cyc();

    chk("iq_left", iq.size(), 0);
    chk("dq_left", dq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
